// File: rtl/xdist_tbl_ram.sv
// Dual-port distributed table RAM: port A read/write with byte enables, port B read-only,
// restartable fill engine, 1- or 2-cycle write-first reads, out-of-range protection.
module xdist_tbl_ram #(
  parameter int DEPTH   = 1024,
  parameter int DEPTH_W = 10,
  parameter int WIDTH_W = 32,
  parameter int BYTE_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                        clk_a,
  input  logic                        rst_n,
  input  logic                        auto_init,
  input  logic [WIDTH_W-1:0]          init_val,
  output logic                        init_busy,
  output logic                        init_done,
  input  logic [WIDTH_W/BYTE_W-1:0]   wren_a,
  input  logic [DEPTH_W-1:0]          addr_a,
  input  logic [WIDTH_W-1:0]          wrdata_a,
  output logic [WIDTH_W-1:0]          rddata_a,
  input  logic [DEPTH_W-1:0]          addr_b,
  output logic [WIDTH_W-1:0]          rddata_b,
  output logic                        wr_drop
);
  localparam int NBYTE = WIDTH_W / BYTE_W;
  localparam logic [DEPTH_W:0]   DEPTH_L = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W-1:0] LAST    = DEPTH_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, INIT, DONE} state_t;

  state_t               state, state_nx;
  logic [DEPTH_W-1:0]   init_addr, init_addr_nx;
  logic [WIDTH_W-1:0]   init_cap, init_cap_nx;
  logic                 drop_nx;

  logic [WIDTH_W-1:0]   mem [DEPTH];

  logic                 a_ok, b_ok, filling, we;
  logic [DEPTH_W-1:0]   wa, ia, ib;
  logic [NBYTE-1:0]     be;
  logic [WIDTH_W-1:0]   src, old, wd, rd_a_now, rd_b_now;
  logic [RD_LAT-1:0][WIDTH_W-1:0] pipe_a, pipe_b;

  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      state     <= IDLE;
      init_addr <= '0;
      init_cap  <= '0;
      wr_drop   <= 1'b0;
    end else begin
      state     <= state_nx;
      init_addr <= init_addr_nx;
      init_cap  <= init_cap_nx;
      wr_drop   <= drop_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    init_addr_nx = init_addr;
    init_cap_nx  = init_cap;
    init_busy    = 1'b0;
    init_done    = 1'b0;
    case (state)
      IDLE, DONE: begin
        init_done = (state == DONE);
        if (auto_init) begin
          state_nx     = INIT;
          init_cap_nx  = init_val;
          init_addr_nx = '0;
        end
      end
      INIT: begin
        init_busy    = 1'b1;
        init_addr_nx = init_addr + 1'b1;
        if (init_addr == LAST) begin
          state_nx     = DONE;
          init_addr_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The fill engine owns the write port for the whole pass; user writes are dropped.
  assign filling = (state == INIT);
  assign a_ok    = {1'b0, addr_a} < DEPTH_L;
  assign b_ok    = {1'b0, addr_b} < DEPTH_L;
  assign we      = rst_n && (filling || (|wren_a && a_ok));
  assign drop_nx = |wren_a && (filling || !a_ok);
  assign wa      = filling ? init_addr : (a_ok ? addr_a : '0);
  assign be      = filling ? '1 : wren_a;
  assign src     = filling ? init_cap : wrdata_a;
  assign old     = mem[wa];
  assign ia      = a_ok ? addr_a : '0;
  assign ib      = b_ok ? addr_b : '0;

  for (genvar g = 0; g < NBYTE; g++) begin : g_merge
    assign wd[g*BYTE_W +: BYTE_W] = be[g] ? src[g*BYTE_W +: BYTE_W] : old[g*BYTE_W +: BYTE_W];
  end

  // Write-first: a read hitting this cycle's write sees the merged word.
  assign rd_a_now = !a_ok ? '0 : (we && wa == addr_a) ? wd : mem[ia];
  assign rd_b_now = !b_ok ? '0 : (we && wa == addr_b) ? wd : mem[ib];

  always_ff @(posedge clk_a) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      pipe_a <= '0;
      pipe_b <= '0;
    end else begin
      pipe_a[0] <= rd_a_now;
      pipe_b[0] <= rd_b_now;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  assign rddata_a = pipe_a[RD_LAT-1];
  assign rddata_b = pipe_b[RD_LAT-1];
endmodule

// File: tb/tb_xdist_tbl_ram.sv
// Directed bench for xdist_tbl_ram: 12-word x 16-bit table, a latency-2 and a latency-1
// instance driven by identical stimulus.
module tb_xdist_tbl_ram;
  logic        clk_a = 1'b0;
  logic        rst_n;
  logic        auto_init;
  logic [15:0] init_val;
  logic [1:0]  wren_a;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] wrdata_a;
  logic        init_busy, init_done, wr_drop;
  logic [15:0] rddata_a, rddata_b;
  logic        init_busy1, init_done1, wr_drop1;
  logic [15:0] rddata_a1, rddata_b1;

  int errors = 0;
  int checks = 0;

  always #5 clk_a = ~clk_a;

  xdist_tbl_ram #(.DEPTH(12), .DEPTH_W(4), .WIDTH_W(16), .BYTE_W(8), .RD_LAT(2)) u_dut (
    .clk_a(clk_a), .rst_n(rst_n), .auto_init(auto_init), .init_val(init_val),
    .init_busy(init_busy), .init_done(init_done), .wren_a(wren_a), .addr_a(addr_a),
    .wrdata_a(wrdata_a), .rddata_a(rddata_a), .addr_b(addr_b), .rddata_b(rddata_b),
    .wr_drop(wr_drop));

  xdist_tbl_ram #(.DEPTH(12), .DEPTH_W(4), .WIDTH_W(16), .BYTE_W(8), .RD_LAT(1)) u_dut1 (
    .clk_a(clk_a), .rst_n(rst_n), .auto_init(auto_init), .init_val(init_val),
    .init_busy(init_busy1), .init_done(init_done1), .wren_a(wren_a), .addr_a(addr_a),
    .wrdata_a(wrdata_a), .rddata_a(rddata_a1), .addr_b(addr_b), .rddata_b(rddata_b1),
    .wr_drop(wr_drop1));

  task automatic tick();
    @(negedge clk_a);
  endtask

  task automatic rd2(input logic [3:0] a, output logic [15:0] da, output logic [15:0] db);
    wren_a = 2'b00;
    addr_a = a;
    addr_b = a;
    tick();
    tick();
    da = rddata_a;
    db = rddata_b;
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d);
    addr_a   = a;
    wren_a   = be;
    wrdata_a = d;
    tick();
    wren_a   = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", init_busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", init_done); end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", wr_drop); end
    checks++; if (rddata_a !== 16'h0) begin errors++; $display("FAIL reset_rda got=%h exp=0000", rddata_a); end
    checks++; if (rddata_b !== 16'h0) begin errors++; $display("FAIL reset_rdb got=%h exp=0000", rddata_b); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_init();
    int n;
    logic [15:0] da, db;
    init_val  = 16'h5A5A;
    auto_init = 1'b1;
    tick();
    auto_init = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != 12) begin errors++; $display("FAIL init_busy_len got=%0d exp=12", n); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got=%b exp=1", init_done); end
    for (int i = 0; i < 13; i++) begin
      rd2(4'(i), da, db);
      checks++;
      if (da !== (i < 12 ? 16'h5A5A : 16'h0) || db !== da)
        begin errors++; $display("FAIL init_read[%0d] got a=%h b=%h exp=%h", i, da, db, (i < 12 ? 16'h5A5A : 16'h0)); end
    end
  endtask

  task automatic test_byte_write();
    logic [15:0] da, db;
    wr(4'd3, 2'b11, 16'h1234);
    wr(4'd3, 2'b10, 16'hFF00);
    rd2(4'd3, da, db);
    checks++; if (da !== 16'hFF34) begin errors++; $display("FAIL byte_write got=%h exp=FF34", da); end
    checks++; if (db !== 16'hFF34) begin errors++; $display("FAIL byte_write_b got=%h exp=FF34", db); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] da, db;
    addr_a = 4'd5; addr_b = 4'd5; wren_a = 2'b11; wrdata_a = 16'hBEEF;
    tick();
    wrdata_a = 16'h0001; addr_b = 4'd0;
    tick();
    wren_a = 2'b00;
    checks++; if (rddata_a !== 16'hBEEF) begin errors++; $display("FAIL wf_a got=%h exp=BEEF", rddata_a); end
    checks++; if (rddata_b !== 16'hBEEF) begin errors++; $display("FAIL wf_b got=%h exp=BEEF", rddata_b); end
    tick();
    checks++; if (rddata_a !== 16'h0001) begin errors++; $display("FAIL wf_second got=%h exp=0001", rddata_a); end
    rd2(4'd5, da, db);
    checks++; if (db !== 16'h0001) begin errors++; $display("FAIL wf_final got=%h exp=0001", db); end
  endtask

  task automatic test_drop();
    int n;
    logic [15:0] da, db;
    init_val  = 16'h7777;
    auto_init = 1'b1;
    tick();
    auto_init = 1'b0;
    wr(4'd2, 2'b11, 16'hDEAD);
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_init got=%b exp=1", wr_drop); end
    tick();
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_init_pulse got=%b exp=0", wr_drop); end
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL drop_wait_done got=%b exp=1", init_done); end
    wr(4'd14, 2'b11, 16'hDEAD);
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_oor got=%b exp=1", wr_drop); end
    tick();
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_oor_pulse got=%b exp=0", wr_drop); end
    for (int i = 0; i < 12; i++) begin
      rd2(4'(i), da, db);
      checks++; if (da !== 16'h7777) begin errors++; $display("FAIL drop_mem[%0d] got=%h exp=7777", i, da); end
    end
    rd2(4'd14, da, db);
    checks++; if (da !== 16'h0) begin errors++; $display("FAIL drop_oor_read got=%h exp=0000", da); end
  endtask

  task automatic test_reset_mid_init();
    logic [15:0] da, db;
    init_val  = 16'h0F0F;
    auto_init = 1'b1;
    tick();
    auto_init = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", init_busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", init_done); end
    for (int i = 0; i < 12; i++) begin
      rd2(4'(i), da, db);
      checks++;
      if (da !== (i < 6 ? 16'h0F0F : 16'h7777))
        begin errors++; $display("FAIL abort_mem[%0d] got=%h exp=%h", i, da, (i < 6 ? 16'h0F0F : 16'h7777)); end
    end
  endtask

  task automatic test_reinit_latency();
    int n;
    logic [15:0] da, db;
    init_val  = 16'h1111;
    auto_init = 1'b1;
    tick();
    auto_init = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reinit_first_done got=%b exp=1", init_done); end
    init_val  = 16'h0000;
    auto_init = 1'b1;
    tick();
    auto_init = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != 12) begin errors++; $display("FAIL reinit_done_low got=%0d exp=12", n); end
    for (int i = 0; i < 12; i++) begin
      rd2(4'(i), da, db);
      checks++; if (da !== 16'h0 || db !== 16'h0) begin errors++; $display("FAIL reinit_mem[%0d] got a=%h b=%h exp=0000", i, da, db); end
    end
    wr(4'd7, 2'b11, 16'hC3C3);
    addr_a = 4'd0; addr_b = 4'd0;
    tick();
    addr_a = 4'd7; addr_b = 4'd7;
    tick();
    addr_a = 4'd0; addr_b = 4'd0;
    checks++; if (rddata_a1 !== 16'hC3C3) begin errors++; $display("FAIL lat1_a got=%h exp=C3C3", rddata_a1); end
    checks++; if (rddata_b1 !== 16'hC3C3) begin errors++; $display("FAIL lat1_b got=%h exp=C3C3", rddata_b1); end
    checks++; if (rddata_a !== 16'h0) begin errors++; $display("FAIL lat2_early got=%h exp=0000", rddata_a); end
    tick();
    checks++; if (rddata_a !== 16'hC3C3) begin errors++; $display("FAIL lat2_a got=%h exp=C3C3", rddata_a); end
    checks++; if (rddata_b !== 16'hC3C3) begin errors++; $display("FAIL lat2_b got=%h exp=C3C3", rddata_b); end
    checks++; if (rddata_a1 !== 16'h0) begin errors++; $display("FAIL lat1_next got=%h exp=0000", rddata_a1); end
  endtask

  initial begin
    rst_n = 1'b0; auto_init = 1'b0; init_val = '0;
    wren_a = '0; addr_a = '0; addr_b = '0; wrdata_a = '0;
    test_reset();
    test_init();
    test_byte_write();
    test_back_to_back();
    test_drop();
    test_reset_mid_init();
    test_reinit_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
